wts_slot_master: RTL and testbench

WTS_SLOT_MASTER -- requirements
Module: wts_slot_master

---
 rtl/wts_slot_master.sv | 203 ++++++++++++++++++++
 tb/tb_wts_slot_master.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wts_slot_master.sv
// Slot bus master: runs one memory read or write cycle (T1, T2, optional TW, T3)
// per accepted command, with cartridge wait-state insertion and a timeout.
module wts_slot_master #(
   parameter int WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_address,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_timeout,
   output logic [15:0] slot_a,
   output logic [7:0]  slot_d_out,
   output logic        slot_d_oe,
   input  logic [7:0]  slot_d_in,
   output logic        slot_nsltsl,
   output logic        slot_nmerq,
   output logic        slot_nrd,
   output logic        slot_nwr,
   input  logic        slot_nwait
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_TW   = 3'd3,
      S_T3   = 3'd4
   } state_t;

   localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

   state_t      state_q, state_d;
   logic [2:0]  tcnt_q, tcnt_d;
   logic [7:0]  wcnt_q, wcnt_d;
   logic        tmo_q, tmo_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;

   logic        ready_q, ready_d;
   logic        valid_q, valid_d;
   logic        tout_q, tout_d;
   logic [15:0] a_q, a_d;
   logic [7:0]  dout_q, dout_d;
   logic        oe_q, oe_d;
   logic        nsltsl_q, nsltsl_d;
   logic        nmerq_q, nmerq_d;
   logic        nrd_q, nrd_d;
   logic        nwr_q, nwr_d;

   logic        front_s;
   logic        mreq_low_s;
   logic        wr_low_s;

   // Sequencer: T-state/clock position, wait accounting and read capture.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      wcnt_d  = wcnt_q;
      tmo_d   = tmo_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = S_T1;
               tcnt_d  = 3'd0;
               wcnt_d  = 8'd0;
               tmo_d   = 1'b0;
               wr_d    = cmd_write;
               addr_d  = cmd_address;
               wdata_d = cmd_wdata;
            end else begin
               tcnt_d  = 3'd0;
            end
         end
         S_T1: begin
            if (tcnt_q == 3'd5) begin
               state_d = S_T2;
               tcnt_d  = 3'd0;
            end else begin
               tcnt_d  = tcnt_q + 3'd1;
            end
         end
         S_T2, S_TW: begin
            if (tcnt_q == 3'd5) begin
               tcnt_d = 3'd0;
               if (!slot_nwait && (wcnt_q < WAIT_MAX)) begin
                  state_d = S_TW;
                  wcnt_d  = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
               end else begin
                  state_d = S_T3;
                  tmo_d   = !slot_nwait;
               end
            end else begin
               tcnt_d = tcnt_q + 3'd1;
            end
         end
         S_T3: begin
            if ((tcnt_q == 3'd3) && !wr_q) begin
               rdata_d = slot_d_in;
            end else begin
               rdata_d = rdata_q;
            end
            if (tcnt_q == 3'd5) begin
               state_d = S_IDLE;
               tcnt_d  = 3'd0;
            end else begin
               tcnt_d  = tcnt_q + 3'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tcnt_d  = 3'd0;
         end
      endcase
   end

   // Output decode from the next position so every pin comes straight from a flop.
   always_comb begin
      front_s    = ((state_d == S_T1) && (tcnt_d >= 3'd3)) ||
                   (state_d == S_T2) || (state_d == S_TW);
      mreq_low_s = front_s ||
                   ((state_d == S_T3) && (tcnt_d <= (wr_d ? 3'd2 : 3'd3)));
      wr_low_s   = wr_d && (((state_d == S_T2) && (tcnt_d >= 3'd3)) ||
                            (state_d == S_TW) ||
                            ((state_d == S_T3) && (tcnt_d <= 3'd2)));
      ready_d    = (state_d == S_IDLE);
      valid_d    = (state_q == S_T3) && (tcnt_q == 3'd5);
      tout_d     = valid_d && tmo_q;
      a_d        = (state_d == S_IDLE) ? 16'h0000 : addr_d;
      oe_d       = wr_d && (front_s || (state_d == S_T3));
      dout_d     = oe_d ? wdata_d : 8'h00;
      nsltsl_d   = !mreq_low_s;
      nmerq_d    = !mreq_low_s;
      nrd_d      = !(mreq_low_s && !wr_d);
      nwr_d      = !wr_low_s;
   end

   // State and output registers; reset drops any cycle in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         tcnt_q   <= 3'd0;
         wcnt_q   <= 8'd0;
         tmo_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 8'h00;
         rdata_q  <= 8'h00;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         tout_q   <= 1'b0;
         a_q      <= 16'h0000;
         dout_q   <= 8'h00;
         oe_q     <= 1'b0;
         nsltsl_q <= 1'b1;
         nmerq_q  <= 1'b1;
         nrd_q    <= 1'b1;
         nwr_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         wcnt_q   <= wcnt_d;
         tmo_q    <= tmo_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         tout_q   <= tout_d;
         a_q      <= a_d;
         dout_q   <= dout_d;
         oe_q     <= oe_d;
         nsltsl_q <= nsltsl_d;
         nmerq_q  <= nmerq_d;
         nrd_q    <= nrd_d;
         nwr_q    <= nwr_d;
      end
   end

   assign cmd_ready   = ready_q;
   assign rsp_valid   = valid_q;
   assign rsp_timeout = tout_q;
   assign rsp_rdata   = rdata_q;
   assign slot_a      = a_q;
   assign slot_d_out  = dout_q;
   assign slot_d_oe   = oe_q;
   assign slot_nsltsl = nsltsl_q;
   assign slot_nmerq  = nmerq_q;
   assign slot_nrd    = nrd_q;
   assign slot_nwr    = nwr_q;

endmodule

// File: tb/tb_wts_slot_master.sv
// Bench for wts_slot_master: directed vector table, reset-abort sequence and
// random commands checked clock by clock against a timing-window model.
module tb_wts_slot_master;

   localparam int WAIT_LIMIT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [15:0] cmd_address = 16'h0000;
   logic [7:0]  cmd_wdata = 8'h00;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_timeout;
   logic [15:0] slot_a;
   logic [7:0]  slot_d_out;
   logic        slot_d_oe;
   logic [7:0]  slot_d_in = 8'h00;
   logic        slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr;
   logic        slot_nwait = 1'b1;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  last_rd = 8'h00;

   wts_slot_master #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .slot_a(slot_a), .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe),
      .slot_d_in(slot_d_in), .slot_nsltsl(slot_nsltsl), .slot_nmerq(slot_nmerq),
      .slot_nrd(slot_nrd), .slot_nwr(slot_nwr), .slot_nwait(slot_nwait)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pins(input logic mask_oe, input logic mask_to);
      return {cmd_ready, rsp_valid, rsp_timeout & mask_to, slot_a, slot_d_oe,
              (mask_oe ? slot_d_out : 8'h00), slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr};
   endfunction

   // One command; nwait is low for cycle clocks c < n_low. Returns observed rsp clock.
   task automatic run_cmd(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] din, input int n_low,
                          output int rsp_at, output logic to_seen);
      int w, t3s, l;
      logic to_m, e_mreq, e_nrd, e_nwr, e_oe;
      logic [31:0] exp;
      w = 0;
      while (w < WAIT_LIMIT && (11 + 6 * w) < n_low) w++;
      to_m = (w == WAIT_LIMIT) && ((11 + 6 * w) < n_low);
      t3s  = 12 + 6 * w;
      l    = t3s + 6;
      cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_wdata = wd;
      slot_d_in = din;
      @(posedge clk); #1;
      rsp_at = -1; to_seen = 1'b0;
      for (int c = 0; c <= l; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         slot_nwait = (c < n_low) ? 1'b0 : 1'b1;
         e_mreq = (c >= 3) && (c <= t3s + (wr ? 2 : 3));
         e_nrd  = !wr && e_mreq;
         e_nwr  = wr && (c >= 9) && (c <= t3s + 2);
         e_oe   = wr && (c >= 3) && (c <= t3s + 5);
         exp = {(c == l), (c == l), (c == l) && to_m, (c < l) ? a : 16'h0000, e_oe,
                (e_oe ? wd : 8'h00), !e_mreq, !e_mreq, !e_nrd, !e_nwr};
         chk($sformatf("pins_c%0d", c), 64'(pins(e_oe, c == l)), 64'(exp));
         if (rsp_valid && rsp_at < 0) begin
            rsp_at  = c;
            to_seen = rsp_timeout;
         end
         if (c == 0) chk("rdata_hold", 64'(rsp_rdata), 64'(last_rd));
         if (c == l) chk("rdata_done", 64'(rsp_rdata), 64'(wr ? last_rd : din));
         if (c < l - 1) begin
            cmd_valid = 1'b1; cmd_write = $urandom_range(0, 1);
            cmd_address = 16'($urandom); cmd_wdata = 8'($urandom);
         end else begin
            cmd_valid = 1'b0;
         end
      end
      if (!wr) last_rd = din;
   endtask

   typedef struct {
      logic        wr;
      logic [15:0] a;
      logic [7:0]  wd;
      logic [7:0]  din;
      int          n_low;
      int          exp_rsp;
      logic        exp_to;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int   rsp_at, n_low, gap;
      logic to_seen, seen_v;

      tbl[0] = '{1'b1, 16'h9000, 8'h3F, 8'h00, 0,    18,  1'b0};
      tbl[1] = '{1'b0, 16'h9800, 8'h00, 8'h7F, 0,    18,  1'b0};
      tbl[2] = '{1'b0, 16'h9800, 8'h00, 8'h55, 18,   30,  1'b0};
      tbl[3] = '{1'b0, 16'h4000, 8'h00, 8'hA5, 1000, 114, 1'b1};
      tbl[4] = '{1'b1, 16'h8123, 8'hC3, 8'h00, 12,   24,  1'b0};
      tbl[5] = '{1'b0, 16'h0001, 8'h00, 8'h3C, 107,  114, 1'b0};
      tbl[6] = '{1'b1, 16'hFFFF, 8'h81, 8'h00, 108,  114, 1'b1};
      tbl[7] = '{1'b0, 16'h0000, 8'h00, 8'h00, 11,   18,  1'b0};

      #12;
      chk("reset_pins", 64'(pins(1'b1, 1'b1)), 64'({1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 4'hF}));
      chk("reset_rdata", 64'(rsp_rdata), 64'h0);
      @(negedge clk); reset = 1'b0;

      // Consecutive entries are offered in the rsp_valid clock: back-to-back.
      for (int i = 0; i < 8; i++) begin
         run_cmd(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].din, tbl[i].n_low, rsp_at, to_seen);
         chk($sformatf("vec%0d_rsp_clock", i), 64'(rsp_at), 64'(tbl[i].exp_rsp));
         chk($sformatf("vec%0d_timeout", i), 64'(to_seen), 64'(tbl[i].exp_to));
      end

      // Reset asserted at T2.4 of a write aborts the cycle immediately.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 16'hA5A5; cmd_wdata = 8'h5A;
      slot_nwait = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_abort_nwr", 64'(slot_nwr), 64'h0);
      #1 reset = 1'b1;
      #1;
      chk("abort_pins", 64'(pins(1'b1, 1'b1)), 64'({1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 4'hF}));
      chk("abort_rdata", 64'(rsp_rdata), 64'h0);
      last_rd = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      seen_v = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (rsp_valid || !cmd_ready) seen_v = 1'b1;
      end
      chk("abort_no_rsp", 64'(seen_v), 64'h0);

      // Random commands with random wait patterns and idle gaps.
      for (int i = 0; i < 25; i++) begin
         case ($urandom_range(0, 3))
            0: n_low = 0;
            1: n_low = $urandom_range(0, 40);
            2: n_low = $urandom_range(100, 120);
            default: n_low = 500;
         endcase
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
         run_cmd(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom),
                 n_low, rsp_at, to_seen);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
